// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with 1-cycle registered reads and a per-register busy scoreboard.
// Optional macro REGFILE_MP_BYPASS_EN: same-cycle write data is forwarded to matching reads.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD-1:0]      rd_en_i,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    input  logic [NWR-1:0]      wr_en_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    input  logic                busy_set_i,
    input  logic [AW-1:0]       busy_set_addr_i,
    output logic [NREGS-1:0]    busy_o
);

    logic [XLEN-1:0]  regs    [NREGS];
    logic [XLEN-1:0]  rd_val  [NRD];
    logic [NREGS-1:0] busy_next;

    // Later write ports overwrite earlier ones, so the highest index wins a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (!(ZERO_REG != 0 && r == 0)) begin
                    for (int w = 0; w < NWR; w++) begin
                        if (wr_en_i[w] && wr_addr_i[w*AW +: AW] == AW'(r)) begin
                            regs[r] <= wr_data_i[w*XLEN +: XLEN];
                        end
                    end
                end
            end
        end
    end

    // Scanning only valid register indices makes out-of-range addresses read as 0.
    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            rd_val[p] = '0;
            for (int r = 0; r < NREGS; r++) begin
                if (rd_addr_i[p*AW +: AW] == AW'(r)) begin
                    rd_val[p] = regs[r];
`ifdef REGFILE_MP_BYPASS_EN
                    for (int w = 0; w < NWR; w++) begin
                        if (wr_en_i[w] && wr_addr_i[w*AW +: AW] == AW'(r)) begin
                            rd_val[p] = wr_data_i[w*XLEN +: XLEN];
                        end
                    end
`endif
                end
            end
            if (ZERO_REG != 0 && rd_addr_i[p*AW +: AW] == '0) begin
                rd_val[p] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_o <= '0;
        end else begin
            for (int p = 0; p < NRD; p++) begin
                if (rd_en_i[p]) begin
                    rd_data_o[p*XLEN +: XLEN] <= rd_val[p];
                end
            end
        end
    end

    // Set is applied after clear: a newly issued producer outranks the one writing back.
    always_comb begin
        busy_next = busy_o;
        for (int r = 0; r < NREGS; r++) begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en_i[w] && wr_addr_i[w*AW +: AW] == AW'(r)) begin
                    busy_next[r] = 1'b0;
                end
            end
            if (busy_set_i && busy_set_addr_i == AW'(r)) begin
                busy_next[r] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            busy_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_o <= '0;
        end else begin
            busy_o <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (2 read ports, 2 write ports, 24 registers, zero register on).
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 24;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int NWR   = 2;

    logic                clk;
    logic                rst_n;
    logic [NRD-1:0]      rd_en;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                busy_set;
    logic [AW-1:0]       busy_set_addr;
    logic [NREGS-1:0]    busy;

    int compared   = 0;
    int mismatched = 0;

    logic [XLEN-1:0] bypass_exp;

    regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rd_en_i         (rd_en),
        .rd_addr_i       (rd_addr),
        .rd_data_o       (rd_data),
        .wr_en_i         (wr_en),
        .wr_addr_i       (wr_addr),
        .wr_data_i       (wr_data),
        .busy_set_i      (busy_set),
        .busy_set_addr_i (busy_set_addr),
        .busy_o          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic idleInputs();
        rd_en         = '0;
        wr_en         = '0;
        busy_set      = 1'b0;
        busy_set_addr = '0;
    endtask

    task automatic setWrite(input int port, input logic [AW-1:0] addr, input logic [XLEN-1:0] data);
        wr_en[port]               = 1'b1;
        wr_addr[port*AW +: AW]    = addr;
        wr_data[port*XLEN +: XLEN] = data;
    endtask

    task automatic setRead(input int port, input logic [AW-1:0] addr);
        rd_en[port]            = 1'b1;
        rd_addr[port*AW +: AW] = addr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        idleInputs();
        #12;
        checkOutput("reset_rd_data", 64'(rd_data), 64'h0);
        checkOutput("reset_busy", 64'(busy), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Read addr 5 on both ports after reset
        setRead(0, 5'd5);
        setRead(1, 5'd5);
        step();
        idleInputs();
        checkOutput("t1_port0", 64'(rd_data[0 +: XLEN]), 64'h0);
        checkOutput("t1_port1", 64'(rd_data[XLEN +: XLEN]), 64'h0);
        checkOutput("t1_busy", 64'(busy), 64'h0);

        // Write then read, then hold with a new write to the same register underneath
        setWrite(0, 5'd7, 32'hDEADBEEF);
        step();
        idleInputs();
        setRead(0, 5'd7);
        step();
        idleInputs();
        checkOutput("t2_read7", 64'(rd_data[0 +: XLEN]), 64'hDEADBEEF);
        rd_addr[0 +: AW] = 5'd9;
        setWrite(0, 5'd7, 32'h11111111);
        for (int i = 0; i < 3; i++) begin
            step();
            idleInputs();
            checkOutput($sformatf("t2_hold%0d", i), 64'(rd_data[0 +: XLEN]), 64'hDEADBEEF);
        end

        // Zero register: write and busy-set are dropped
        setWrite(0, 5'd0, 32'h12345678);
        busy_set      = 1'b1;
        busy_set_addr = 5'd0;
        step();
        idleInputs();
        checkOutput("t3_busy", 64'(busy), 64'h0);
        setRead(1, 5'd0);
        step();
        idleInputs();
        checkOutput("t3_read0", 64'(rd_data[XLEN +: XLEN]), 64'h0);
        checkOutput("t3_port0_held", 64'(rd_data[0 +: XLEN]), 64'hDEADBEEF);

        // Write-port collision: port 1 wins
        setWrite(0, 5'd3, 32'h1);
        setWrite(1, 5'd3, 32'h2);
        step();
        idleInputs();
        setRead(0, 5'd3);
        setRead(1, 5'd7);
        step();
        idleInputs();
        checkOutput("t4_collision", 64'(rd_data[0 +: XLEN]), 64'h2);
        checkOutput("t4_read7", 64'(rd_data[XLEN +: XLEN]), 64'h11111111);

        // Read during write of the same register
`ifdef REGFILE_MP_BYPASS_EN
        bypass_exp = 32'hA5A5A5A5;
`else
        bypass_exp = 32'h0;
`endif
        setWrite(0, 5'd9, 32'hA5A5A5A5);
        setRead(0, 5'd9);
        step();
        idleInputs();
        checkOutput("t5_same_cycle", 64'(rd_data[0 +: XLEN]), 64'(bypass_exp));
        setRead(0, 5'd9);
        step();
        idleInputs();
        checkOutput("t5_after", 64'(rd_data[0 +: XLEN]), 64'hA5A5A5A5);

        // Out-of-range address: write ignored, read returns 0, busy-set ignored
        setWrite(1, 5'd30, 32'hCAFEF00D);
        busy_set      = 1'b1;
        busy_set_addr = 5'd30;
        step();
        idleInputs();
        checkOutput("oor_busy", 64'(busy), 64'h0);
        setRead(1, 5'd30);
        step();
        idleInputs();
        checkOutput("oor_read", 64'(rd_data[XLEN +: XLEN]), 64'h0);

        // Scoreboard: set, then set+clear (set wins), then clear
        busy_set      = 1'b1;
        busy_set_addr = 5'd4;
        step();
        idleInputs();
        checkOutput("t6_set", 64'(busy), 64'h10);
        step();
        setWrite(0, 5'd4, 32'h44);
        busy_set      = 1'b1;
        busy_set_addr = 5'd4;
        step();
        idleInputs();
        checkOutput("t6_set_wins", 64'(busy), 64'h10);
        setWrite(1, 5'd4, 32'h45);
        step();
        idleInputs();
        checkOutput("t6_clear", 64'(busy), 64'h0);

        // Asynchronous reset mid-operation with a write in flight
        busy_set      = 1'b1;
        busy_set_addr = 5'd6;
        setRead(0, 5'd4);
        step();
        idleInputs();
        checkOutput("pre_rst_busy", 64'(busy), 64'h40);
        checkOutput("pre_rst_read4", 64'(rd_data[0 +: XLEN]), 64'h45);
        setWrite(0, 5'd8, 32'h88888888);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_rd_data", 64'(rd_data), 64'h0);
        checkOutput("async_rst_busy", 64'(busy), 64'h0);
        @(negedge clk);
        idleInputs();
        rst_n = 1'b1;

        // First post-reset edge behaves normally
        setWrite(0, 5'd10, 32'h0BADF00D);
        setRead(0, 5'd8);
        setRead(1, 5'd7);
        step();
        idleInputs();
        checkOutput("post_rst_read8", 64'(rd_data[0 +: XLEN]), 64'h0);
        checkOutput("post_rst_read7", 64'(rd_data[XLEN +: XLEN]), 64'h0);
        setRead(1, 5'd10);
        step();
        idleInputs();
        checkOutput("post_rst_read10", 64'(rd_data[XLEN +: XLEN]), 64'h0BADF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
